// File: rtl/uu_wlan_tx_frame_sender.sv
// LMAC transmit sequencer: emits the TXVECTOR under a txstart request, streams PSDU
// bytes from the packet buffer against per-byte FIFO credits, then closes with txend.
module uu_wlan_tx_frame_sender #(
    parameter int VEC_LEN    = 8,
    parameter int LEN_W      = 12,
    parameter int TMO_CYCLES = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             tx_go,
    input  logic [LEN_W-1:0] tx_len,
    output logic [3:0]       txvec_idx,
    input  logic [7:0]       txvec_byte,
    output logic             buf_rd_en,
    output logic [LEN_W-1:0] buf_rd_addr,
    input  logic [7:0]       buf_rd_data,
    output logic             mac2fifo_txstart_req,
    output logic             mac2fifo_txend_req,
    output logic [7:0]       mac2fifo_phy_frame,
    output logic             mac2fifo_frame_val,
    input  logic             fifo2mac_txstart_confirm,
    input  logic             fifo2mac_txdata_confirm,
    input  logic             fifo2mac_txend_confirm,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_abort
);

    typedef enum logic [2:0] {
        IDLE, VEC, WAIT_SCFM, DATA, END_REQ, WAIT_ECFM
    } state_t;

    localparam int              TMR_W    = LEN_W + 4;
    localparam logic [TMR_W-1:0] TMO     = TMR_W'(TMO_CYCLES);
    localparam logic [3:0]       VEC_LAST = 4'(VEC_LEN - 1);

    state_t           state_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] issued_reg;
    logic [3:0]       idx_reg;
    logic [TMR_W-1:0] timer_reg;
    logic             scfm_seen_reg;
    logic             present_reg;
    logic             present_last_reg;

    logic run;
    logic start_ok;
    logic timed_out;
    logic in_vec;
    logic in_data_byte;

    assign run          = rst_n & enable;
    assign start_ok     = fifo2mac_txstart_confirm | scfm_seen_reg;
    assign timed_out    = (timer_reg == TMO);
    assign in_vec       = (state_reg == VEC);
    assign in_data_byte = (state_reg == DATA) & present_reg;

    // Reads are issued in the same cycle as the credit so the byte follows one cycle later.
    assign buf_rd_en   = run & (state_reg == DATA) & fifo2mac_txdata_confirm
                         & (issued_reg < len_reg);
    assign buf_rd_addr = issued_reg;

    assign txvec_idx            = in_vec ? idx_reg : 4'd0;
    assign mac2fifo_txstart_req = in_vec & (idx_reg == 4'd0);
    assign mac2fifo_txend_req   = (state_reg == END_REQ);
    assign mac2fifo_frame_val   = in_vec | in_data_byte;
    assign mac2fifo_phy_frame   = in_vec       ? txvec_byte  :
                                  in_data_byte ? buf_rd_data : 8'd0;
    assign tx_busy              = (state_reg != IDLE);

    // End confirm outranks a coincident timeout.
    assign tx_done  = run & (state_reg == WAIT_ECFM) & fifo2mac_txend_confirm;
    assign tx_abort = run & ~tx_done & timed_out &
                      (((state_reg == WAIT_SCFM) & ~start_ok) | (state_reg == WAIT_ECFM));

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            state_reg        <= IDLE;
            len_reg          <= '0;
            issued_reg       <= '0;
            idx_reg          <= 4'd0;
            timer_reg        <= '0;
            scfm_seen_reg    <= 1'b0;
            present_reg      <= 1'b0;
            present_last_reg <= 1'b0;
        end else begin
            present_reg      <= buf_rd_en;
            present_last_reg <= buf_rd_en & (issued_reg == (len_reg - LEN_W'(1)));
            if (buf_rd_en) begin
                issued_reg <= issued_reg + LEN_W'(1);
            end
            if (timer_reg != '1) begin
                timer_reg <= timer_reg + TMR_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (tx_go) begin
                        len_reg       <= tx_len;
                        issued_reg    <= '0;
                        idx_reg       <= 4'd0;
                        timer_reg     <= '0;
                        scfm_seen_reg <= 1'b0;
                        state_reg     <= VEC;
                    end
                end
                VEC: begin
                    // An early start confirm is held until the wait state can consume it.
                    if (fifo2mac_txstart_confirm) begin
                        scfm_seen_reg <= 1'b1;
                    end
                    idx_reg <= idx_reg + 4'd1;
                    if (idx_reg == VEC_LAST) begin
                        timer_reg <= '0;
                        state_reg <= WAIT_SCFM;
                    end
                end
                WAIT_SCFM: begin
                    if (start_ok) begin
                        scfm_seen_reg <= 1'b0;
                        timer_reg     <= '0;
                        state_reg     <= (len_reg != '0) ? DATA : END_REQ;
                    end else if (timed_out) begin
                        state_reg <= IDLE;
                    end
                end
                DATA: begin
                    if (present_last_reg) begin
                        timer_reg <= '0;
                        state_reg <= END_REQ;
                    end
                end
                END_REQ: begin
                    timer_reg <= '0;
                    state_reg <= WAIT_ECFM;
                end
                WAIT_ECFM: begin
                    if (fifo2mac_txend_confirm || timed_out) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
